// File: rtl/trace_pkg.sv
// Shared types for the retired-instruction trace transmitter.
// Holds the frame length, the transmit FSM encoding and the 64-bit trace entry layout.
package trace_pkg;

    localparam int FRAME_BYTES = 9;
    localparam int ENTRY_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace entries; dout shows the head entry combinationally, push/pop take effect on the next edge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle; entries are never overwritten.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Buffers retired (pc, inst) pairs and sends each as a 9-byte 8N1 UART frame; txd falls one edge after the head entry is available.
// No backpressure to the core: captures into a full FIFO are dropped and counted, enable only gates the start of new frames.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int         DEPTH        = 16,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   trace_valid,
    input  logic [31:0]            trace_pc,
    input  logic [31:0]            trace_inst,
    input  logic                   enable,
    output logic                   txd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            drop_count
);

    localparam int         CW        = $clog2(CLKS_PER_BIT);
    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    state_t             state;
    entry_t             cap;
    entry_t             head;
    logic [ENTRY_W-1:0] shreg;
    logic [7:0]         tx_byte;
    logic [3:0]         byte_idx;
    logic [2:0]         bit_idx;
    logic [CW-1:0]      tick;
    logic               fifo_full;
    logic               fifo_empty;
    logic               bit_end;
    logic               frame_end;
    logic               pop;
    logic               drop;

    assign cap       = '{pc: trace_pc, inst: trace_inst};
    assign bit_end   = (tick == CW'(CLKS_PER_BIT - 1));
    assign frame_end = (state == STOP) && bit_end && (byte_idx == LAST_BYTE);
    // A new frame may start from idle or seamlessly at the end of the last stop bit.
    assign pop       = enable && !fifo_empty && ((state == IDLE) || frame_end);
    assign drop      = trace_valid && fifo_full && !pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .push   (trace_valid),
        .pop    (pop),
        .din    (cap),
        .dout   (head),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            tx_byte  <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            tick     <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            tick <= ((state == IDLE) || bit_end) ? '0 : tick + CW'(1);
            if (pop) begin
                state    <= START;
                shreg    <= head;
                tx_byte  <= SYNC_BYTE;
                byte_idx <= '0;
                txd      <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    START: if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= tx_byte[0];
                        tx_byte <= {1'b0, tx_byte[7:1]};
                    end
                    DATA: if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= tx_byte[0];
                            tx_byte <= {1'b0, tx_byte[7:1]};
                        end
                    end
                    STOP: if (bit_end) begin
                        if (byte_idx != LAST_BYTE) begin
                            state    <= START;
                            byte_idx <= byte_idx + 4'd1;
                            tx_byte  <= shreg[ENTRY_W-1 -: 8];
                            shreg    <= {shreg[ENTRY_W-9:0], 8'h00};
                            txd      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: waveform-level model checked every cycle, UART receiver decoding frames, directed scenarios.
module tb_trace_uart_tx;

    localparam int         DEPTH = 4;
    localparam int         CPB   = 4;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk_in      = 1'b0;
    logic        reset       = 1'b1;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_pc    = '0;
    logic [31:0] trace_inst  = '0;
    logic        enable      = 1'b0;
    logic        txd;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    trace_uart_tx #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_inst  (trace_inst),
        .enable      (enable),
        .txd         (txd),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queue of buffered entries plus the exact txd level expected for each remaining cycle of the current frame.
    logic [63:0] mq[$];
    bit          wave[$];
    int unsigned mdrop = 0;
    bit          chk_en = 0;

    function automatic void add_frame(input logic [63:0] e);
        logic [71:0] f;
        logic [7:0]  by;
        bit          v;
        f = {SYNC, e};
        for (int b = 0; b < 9; b++) begin
            by = f[71-8*b -: 8];
            for (int k = 0; k < 10; k++) begin
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : by[k-1];
                for (int c = 0; c < CPB; c++) wave.push_back(v);
            end
        end
    endfunction

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            mq.delete();
            wave.delete();
            mdrop = 0;
        end else begin
            bit popped;
            int lvl;
            popped = 0;
            lvl    = mq.size();
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && enable && lvl > 0) begin
                add_frame(mq.pop_front());
                popped = 1;
            end
            if (trace_valid) begin
                if (lvl < DEPTH || popped) mq.push_back({trace_pc, trace_inst});
                else if (mdrop < 16'hFFFF) mdrop++;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("txd", txd, (wave.size() > 0) ? wave[0] : 1'b1);
            chk("busy", busy, wave.size() > 0);
            chk("fifo_level", fifo_level, mq.size());
            chk("drop_count", drop_count, mdrop);
        end
    end

    // Observers: peak level, length of the last busy run, and a UART receiver sampling mid-bit.
    int peak = 0;
    int run = 0;
    int last_run = 0;
    always @(negedge clk_in) begin
        if (int'(fifo_level) > peak) peak = fifo_level;
        if (busy) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    bit         rx_act = 0;
    int         rx_t = 0;
    always @(negedge clk_in) begin
        if (!reset) rx_act = 0;
        else if (!rx_act) begin
            if (txd == 1'b0) begin
                rx_act = 1;
                rx_t   = 0;
            end
        end else rx_t++;
        if (rx_act && (rx_t % CPB == 2)) begin
            int k;
            k = rx_t / CPB;
            if (k >= 1 && k <= 8) rx_sh[k-1] = txd;
            if (k == 9) begin
                chk("stop_bit", txd, 1'b1);
                rx_q.push_back(rx_sh);
                rx_act = 0;
            end
        end
    end

    function automatic logic [7:0] rx_pop();
        if (rx_q.size() == 0) return 8'hxx;
        return rx_q.pop_front();
    endfunction

    task automatic check_frame(input string name, input logic [31:0] pc, input logic [31:0] inst);
        logic [71:0] f;
        f = {SYNC, pc, inst};
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_b%0d", name, i), rx_pop(), f[71-8*i -: 8]);
        end
    endtask

    task automatic strobe(input logic [31:0] pc, input logic [31:0] inst);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_inst  = inst;
        @(negedge clk_in);
        trace_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    logic [7:0] exp1 [9] = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h10, 8'h01};

    initial begin
        #2 reset = 1'b0;
        chk_en = 1;
        repeat (5) @(negedge clk_in);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        reset  = 1'b1;
        enable = 1'b1;
        repeat (100) @(negedge clk_in);
        chk("idle_txd", txd, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Single frame
        strobe(32'h00400000, 32'h3C011001);
        chk("cap_level", fifo_level, 1);
        chk("cap_txd", txd, 1'b1);
        @(negedge clk_in);
        chk("start_txd", txd, 1'b0);
        chk("start_busy", busy, 1'b1);
        chk("start_level", fifo_level, 0);
        wait_idle("f1", 400);
        repeat (20) @(negedge clk_in);
        chk("f1_busy_len", last_run, 360);
        chk("f1_nbytes", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) chk($sformatf("f1_b%0d", i), rx_pop(), exp1[i]);

        // Back-to-back frames
        for (int i = 0; i < 3; i++) strobe(32'h10000000 + 32'(i * 4), 32'hA0000000 | 32'(i));
        wait_idle("b2b", 1200);
        repeat (20) @(negedge clk_in);
        chk("b2b_busy_len", last_run, 1080);
        chk("b2b_nbytes", rx_q.size(), 27);
        for (int i = 0; i < 3; i++)
            check_frame($sformatf("b2b%0d", i), 32'h10000000 + 32'(i * 4), 32'hA0000000 | 32'(i));

        // Overflow
        peak = 0;
        for (int i = 0; i < 10; i++) strobe(32'h20000000 + 32'(i * 16), 32'h5A000000 + 32'(i));
        chk("ovf_drop", drop_count, 5);
        chk("ovf_peak", peak, 4);
        wait_idle("ovf", 2000);
        repeat (20) @(negedge clk_in);
        chk("ovf_nbytes", rx_q.size(), 45);
        for (int i = 0; i < 5; i++)
            check_frame($sformatf("ovf%0d", i), 32'h20000000 + 32'(i * 16), 32'h5A000000 + 32'(i));

        // Enable gating
        enable = 1'b0;
        strobe(32'h30000000, 32'h11111111);
        strobe(32'h30000004, 32'h22222222);
        repeat (20) @(negedge clk_in);
        chk("en_txd", txd, 1'b1);
        chk("en_level", fifo_level, 2);
        chk("en_busy", busy, 1'b0);
        enable = 1'b1;
        @(negedge clk_in);
        chk("en_start_busy", busy, 1'b1);
        repeat (100) @(negedge clk_in);
        enable = 1'b0;
        wait_idle("en1", 400);
        repeat (30) @(negedge clk_in);
        chk("en_hold_level", fifo_level, 1);
        chk("en_hold_txd", txd, 1'b1);
        chk("en_hold_busy", busy, 1'b0);
        check_frame("en0", 32'h30000000, 32'h11111111);
        enable = 1'b1;
        @(negedge clk_in);
        wait_idle("en2", 400);
        repeat (20) @(negedge clk_in);
        check_frame("en1", 32'h30000004, 32'h22222222);

        // Asynchronous reset in data bit 3 of byte 2
        strobe(32'h00F70000, 32'h01234567);
        strobe(32'h40000000, 32'h89ABCDEF);
        repeat (97) @(negedge clk_in);
        chk("pre_rst_txd", txd, 1'b0);
        chk("pre_rst_level", fifo_level, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_txd", txd, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_level", fifo_level, 0);
        chk("arst_drop", drop_count, 0);
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        rx_q.delete();
        strobe(32'h00400010, 32'h8C080004);
        @(negedge clk_in);
        chk("post_rst_busy", busy, 1'b1);
        wait_idle("post_rst", 400);
        repeat (20) @(negedge clk_in);
        chk("post_rst_nbytes", rx_q.size(), 9);
        check_frame("post_rst", 32'h00400010, 32'h8C080004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Hardware counterpart to the simulation trace logger. Captures every retired (pc, inst) pair from the sccomp_dataflow core and buffers it in a FIFO.
- Serializes each entry as a framed byte stream on a UART 8N1 transmit line, so a board-level run produces the same pc/instr trace a host can compare against the simulator output.
- Sits beside the CPU at top level, fed by the core's pc/inst outputs and a retire strobe.

Parameters:
- DEPTH, 16, FIFO entries of 64 bits each (pc, inst); power of two, at least 2.
- CLKS_PER_BIT, 868, clk_in cycles per UART bit; at least 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk_in  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- trace_valid  input  1  one-cycle strobe: trace_pc/trace_inst hold a retired instruction.
- trace_pc  input  32  PC of the retired instruction.
- trace_inst  input  32  instruction word.
- enable  input  1  permits starting new frames.
- txd  output  1  UART serial out; idles high.
- busy  output  1  high while a frame is being shifted.
- fifo_level  output  $clog2(DEPTH)+1  current entry count.
- drop_count  output  16  saturating count of entries lost to a full FIFO.

Behaviour:
- Reset (reset low, asynchronous): txd=1, busy=0, fifo_level=0, drop_count=0. FSM goes to IDLE; pointers, byte index and bit counters clear. Any frame in flight is abandoned, and txd returns high immediately.
- Capture:
  - trace_valid=1 pushes {trace_pc, trace_inst} if fifo_level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and drop_count increments, saturating at 16'hFFFF.
  - The FIFO never overwrites an entry.
- Frame: 9 bytes sent back to back with no idle bits between them.
  - Byte 0: SYNC_BYTE.
  - Bytes 1-4: trace_pc, MSB byte first.
  - Bytes 5-8: trace_inst, MSB byte first.
  - Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: when enable=1 and FIFO is non-empty. The head entry pops into a 64-bit shift register on that edge, the byte index is set to 0, and busy rises.
  - START -> DATA: after CLKS_PER_BIT cycles.
  - DATA -> STOP: after 8 bit periods.
  - STOP -> START: after one bit period, if byte index < 8; the index increments.
  - STOP -> IDLE: after one bit period, if byte index = 8.
  - STOP -> START with a new pop: at the end of the final stop bit, if enable=1 and the FIFO is non-empty, the next frame starts with no idle gap.
- Latency: a trace_valid captured at edge N into an empty FIFO with the FSM idle and enable=1 pops at edge N+1. txd falls at edge N+1 (registered output), and busy=1 from edge N+1.
- Frame length: 90*CLKS_PER_BIT cycles.
- enable low: a frame in progress always completes; no new frame starts while enable=0. Capture continues regardless of enable.
- Simultaneous push and pop: fifo_level is unchanged. When full, the push is accepted and drop_count is unchanged.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. fifo_level is a separate counter.
- txd is driven from a flop (glitch-free).

Decomposition:
- Shared package trace_pkg holds: FRAME_BYTES=9, the state encoding (IDLE/START/DATA/STOP), and the trace entry width of 64.
- One sub-module, trace_fifo: synchronous FIFO with push, pop, dout, level and full/empty.
- trace_uart_tx instantiates trace_fifo and contains the frame FSM, the bit timer and drop_count.

Test Plan:
- Reset idle: hold reset low 5 cycles, then release with no traffic for 100 cycles -> txd=1, busy=0, fifo_level=0, drop_count=0 throughout.
- Single frame: CLKS_PER_BIT=4, one strobe with pc=32'h00400000, inst=32'h3C011001 -> decoded bytes A5 00 40 00 00 3C 01 10 01, busy high for exactly 360 cycles, txd low from the edge after capture.
- Back-to-back frames: 3 strobes on consecutive cycles -> 3 frames over 1080 contiguous busy cycles, in capture order, with no idle bit between frames.
- Overflow: DEPTH=4, CLKS_PER_BIT=4, 10 strobes on consecutive cycles -> 1 entry popped plus 4 buffered, drop_count=5, first five pc values transmitted, fifo_level peaks at 4.
- Enable gating: enable=0 with 2 entries queued -> txd stays 1 and fifo_level=2. Raise enable -> transmission starts, and dropping enable mid-frame still completes that frame before stopping.
- Async reset mid-frame: assert reset during data bit 3 of byte 2 -> txd=1, busy=0 and fifo_level=0 immediately without waiting for a clock edge. After release, the next strobe produces a clean frame starting with A5.
